axi_serial_rx_mlane: RTL and testbench

Parametrised successor to the single-lane serial-to-AXI-Stream receiver. Samples a source-synchronous serial bus (`sclk`, `NUM_LANES` data lanes, one `svalid`) entirely in the AXI clock domain, assembles words, and buffers them in an internal FIFO. The FIFO drives an AXI4-Stream master with packet framing (`tlast`) and drop/framing status. Differential input buffers sit in the board-level wrapper; this block takes single-ended, already-buffered signals.

---
 rtl/axi_serial_rx_mlane_pkg.sv | 33 +++
 rtl/axi_serial_rx_mlane_if.sv | 14 +
 rtl/axi_serial_rx_mlane_axis_rx_fifo.sv | 74 +++++++
 rtl/axi_serial_rx_mlane.sv | 189 ++++++++++++++++++
 tb/tb_axi_serial_rx_mlane.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_serial_rx_mlane_pkg.sv
// Shared constants and elaboration helpers for the multi-lane serial receiver.
// Holds the clog2 helper, the lane/width legality check and the status counter width.
package axi_serial_rx_mlane_pkg;

  localparam int STAT_CNT_W = 16;

  // Classification of one synchronised sclk rising edge.
  typedef enum logic [1:0] {
    SMP_NONE = 2'd0,
    SMP_BIT  = 2'd1,
    SMP_END  = 2'd2
  } sample_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  function automatic bit lanes_legal(input int lanes, input int width);
    return ((lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8)) &&
           (width >= 8) && (width % 8 == 0) && (width % lanes == 0);
  endfunction

endpackage

// File: rtl/axi_serial_rx_mlane_if.sv
// AXI4-Stream bundle carried between the receiver (master) and its consumer (slave).
// tdata/tlast are held stable by the master while tvalid is high and tready is low.
interface axi_serial_rx_mlane_if #(
  parameter int DATA_W = 32
) ();
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axi_serial_rx_mlane_axis_rx_fifo.sv
// axis_rx_fifo: synchronous FIFO with show-ahead head taken straight from storage flops.
// One-cycle write-to-valid; a write into a full FIFO lands only when a read retires that cycle.
module axis_rx_fifo
  import axi_serial_rx_mlane_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_acc,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_fire;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_vld  = !empty;
  // Head is zeroed while empty so a freshly reset FIFO presents clean data.
  assign rd_dat  = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_fire = rd_vld && rd_rdy;
  assign wr_acc  = wr_vld && (!full || rd_fire);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_acc, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_serial_rx_mlane.sv
// Multi-lane source-synchronous serial to AXI4-Stream receiver: sync, word assembly, framing, FIFO.
// Sticky status (overflow, frame_err, drop_count, status_clr) exists only with AXI_SERIAL_RX_STATUS_EN.
module axi_serial_rx_mlane
  import axi_serial_rx_mlane_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_LANES              = 1,
  parameter int FIFO_DEPTH             = 16,
  parameter int BEATS_PER_PACKET       = 4
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  sclk,
  input  logic [NUM_LANES-1:0]  sdata,
  input  logic                  svalid,
  axi_serial_rx_mlane_if.master m00_axis,
  input  logic                  status_clr,
  output logic                  overflow,
  output logic                  frame_err,
  output logic [STAT_CNT_W-1:0] drop_count
);

  localparam int W      = C_M00_AXIS_TDATA_WIDTH;
  localparam int GROUPS = W / NUM_LANES;
  localparam int BC_W   = cnt_w(GROUPS);
  localparam int BT_W   = cnt_w(BEATS_PER_PACKET);

  if (!lanes_legal(NUM_LANES, W)) begin : g_lane_cfg_err
    $error("axi_serial_rx_mlane: illegal NUM_LANES / data width combination");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_cfg_err
    $error("axi_serial_rx_mlane: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [2:0]           sclk_sync_q, sclk_sync_d;
  logic [NUM_LANES-1:0] sdata_s1_q, sdata_s1_d, sdata_s2_q, sdata_s2_d;
  logic                 svalid_s1_q, svalid_s1_d, svalid_s2_q, svalid_s2_d;
  logic [W-1:0]         shreg_q, shreg_d, word_nxt;
  logic [BC_W-1:0]      bitcnt_q, bitcnt_d;
  logic [BT_W-1:0]      beat_q, beat_d;
  sample_e              sample_kind;
  logic                 word_done, word_last, frame_evt;
  logic                 fifo_acc, fifo_vld, fifo_full, fifo_empty;
  logic [W:0]           fifo_head;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    sdata_s1_d  = sdata;
    sdata_s2_d  = sdata_s1_q;
    svalid_s1_d = svalid;
    svalid_s2_d = svalid_s1_q;
  end

  // The third sclk stage only serves edge detection; data is taken from the second stage.
  always_comb begin
    sample_kind = SMP_NONE;
    if (sclk_sync_q[1] && !sclk_sync_q[2]) begin
      sample_kind = svalid_s2_q ? SMP_BIT : SMP_END;
    end
  end

  assign word_nxt  = (shreg_q << NUM_LANES) | W'(sdata_s2_q);
  assign word_last = (beat_q == BT_W'(BEATS_PER_PACKET - 1));

  always_comb begin
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    beat_d    = beat_q;
    word_done = 1'b0;
    frame_evt = 1'b0;
    case (sample_kind)
      SMP_BIT: begin
        if (bitcnt_q == BC_W'(GROUPS - 1)) begin
          word_done = 1'b1;
          bitcnt_d  = '0;
          // Dropped words still count here so packet boundaries stay aligned.
          beat_d    = word_last ? '0 : beat_q + BT_W'(1);
        end else begin
          shreg_d  = word_nxt;
          bitcnt_d = bitcnt_q + BC_W'(1);
        end
      end
      SMP_END: begin
        frame_evt = (bitcnt_q != '0) || (beat_q != '0);
        bitcnt_d  = '0;
        beat_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      sclk_sync_q <= '0;
      sdata_s1_q  <= '0;
      sdata_s2_q  <= '0;
      svalid_s1_q <= 1'b0;
      svalid_s2_q <= 1'b0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      beat_q      <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sdata_s1_q  <= sdata_s1_d;
      sdata_s2_q  <= sdata_s2_d;
      svalid_s1_q <= svalid_s1_d;
      svalid_s2_q <= svalid_s2_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      beat_q      <= beat_d;
    end
  end

  axis_rx_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (m00_axis_aclk),
    .rst_n  (m00_axis_aresetn),
    .wr_vld (word_done),
    .wr_dat ({word_last, word_nxt}),
    .wr_acc (fifo_acc),
    .rd_rdy (m00_axis.tready),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m00_axis.tvalid = fifo_vld;
  assign m00_axis.tdata  = fifo_head[W-1:0];
  assign m00_axis.tlast  = fifo_head[W];
  assign m00_axis.tstrb  = '1;

  logic unused_fifo_flags;
  assign unused_fifo_flags = fifo_full ^ fifo_empty;

`ifdef AXI_SERIAL_RX_STATUS_EN
  logic                  overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d;
  logic [STAT_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  drop_evt;

  assign drop_evt = word_done && !fifo_acc;

  // Clear is applied first so a same-cycle set event takes priority.
  always_comb begin
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    drop_cnt_d  = drop_cnt_q;
    if (status_clr) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
      drop_cnt_d  = '0;
    end
    if (drop_evt) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + STAT_CNT_W'(1);
    end
    if (frame_evt) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign drop_count = drop_cnt_q;
`else
  logic unused_status;
  assign unused_status = status_clr ^ frame_evt ^ fifo_acc;

  assign overflow   = 1'b0;
  assign frame_err  = 1'b0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axi_serial_rx_mlane.sv
// Scoreboard bench for axi_serial_rx_mlane: randomized serial frames, queue-based expected beats.
// Status expectations follow AXI_SERIAL_RX_STATUS_EN (tied-zero outputs when it is undefined).
module tb_axi_serial_rx_mlane;
  import axi_serial_rx_mlane_pkg::*;

  localparam int W      = 32;
  localparam int L      = 4;
  localparam int DEPTH  = 4;
  localparam int BPP    = 4;
  localparam int GROUPS = W / L;
`ifdef AXI_SERIAL_RX_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  sclk = 1'b0;
  logic                  svalid = 1'b0;
  logic                  status_clr = 1'b0;
  logic [L-1:0]          sdata = '0;
  logic                  overflow, frame_err;
  logic [STAT_CNT_W-1:0] drop_count;

  axi_serial_rx_mlane_if #(.DATA_W(W)) axis_if ();

  axi_serial_rx_mlane #(
    .C_M00_AXIS_TDATA_WIDTH (W),
    .NUM_LANES              (L),
    .FIFO_DEPTH             (DEPTH),
    .BEATS_PER_PACKET       (BPP)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rstn),
    .sclk             (sclk),
    .sdata            (sdata),
    .svalid           (svalid),
    .m00_axis         (axis_if),
    .status_clr       (status_clr),
    .overflow         (overflow),
    .frame_err        (frame_err),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] frame_words[$];
  int         rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  bit         ovf_m = 1'b0;
  bit         ferr_m = 1'b0;
  int         drops_m = 0;
  bit         prev_stall = 1'b0;
  logic [W:0] prev_beat = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_status(input string tag);
    check({tag, " overflow"},   64'(overflow),   STAT_EN ? 64'(ovf_m)   : 64'd0);
    check({tag, " frame_err"},  64'(frame_err),  STAT_EN ? 64'(ferr_m)  : 64'd0);
    check({tag, " drop_count"}, 64'(drop_count), STAT_EN ? 64'(drops_m) : 64'd0);
  endtask

  initial begin
    axis_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       axis_if.tready = 1'b1;
        1:       axis_if.tready = 1'($urandom_range(0, 1));
        default: axis_if.tready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", 64'(axis_if.tvalid), 64'd1);
        check("hold_beat", 64'({axis_if.tlast, axis_if.tdata}), 64'(prev_beat));
      end
      if (axis_if.tvalid && axis_if.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {axis_if.tlast, axis_if.tdata});
        end else begin
          check("beat {tlast,tdata}", 64'({axis_if.tlast, axis_if.tdata}), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = axis_if.tvalid && !axis_if.tready;
      prev_beat  = {axis_if.tlast, axis_if.tdata};
    end
  end

  task automatic send_group(input logic [L-1:0] g, input logic v);
    sdata  = g;
    svalid = v;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Sends frame_words MSB group first, then `partial` extra groups, then one idle sample.
  task automatic send_frame(input int partial);
    logic [W-1:0] w;
    int n;
    n = frame_words.size();
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      if (rdy_mode == 2 && exp_q.size() >= DEPTH) begin
        ovf_m = 1'b1;
        drops_m++;
      end else begin
        exp_q.push_back({((i + 1) % BPP == 0), w});
      end
      for (int g = 0; g < GROUPS; g++) send_group(w[W-1-g*L -: L], 1'b1);
    end
    for (int g = 0; g < partial; g++) send_group(L'($urandom), 1'b1);
    send_group('0, 1'b0);
    if (partial != 0 || n % BPP != 0) ferr_m = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic fill_words(input int n, input bit rnd, input logic [W-1:0] base);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back(rnd ? W'($urandom) : base + W'(i));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("tvalid_idle", 64'(axis_if.tvalid), 64'd0);
  endtask

  task automatic do_clr();
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    @(negedge clk);
    ovf_m   = 1'b0;
    ferr_m  = 1'b0;
    drops_m = 0;
  endtask

  task automatic apply_reset();
    logic [W/8-1:0] strb_exp;
    strb_exp = '1;
    svalid = 1'b0;
    sdata  = '0;
    sclk   = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst tvalid", 64'(axis_if.tvalid), 64'd0);
    check("rst tdata", 64'(axis_if.tdata), 64'd0);
    check("rst tlast", 64'(axis_if.tlast), 64'd0);
    check("rst tstrb", 64'(axis_if.tstrb), 64'(strb_exp));
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst frame_err", 64'(frame_err), 64'd0);
    check("rst drop_count", 64'(drop_count), 64'd0);
    rstn = 1'b1;
    ovf_m   = 1'b0;
    ferr_m  = 1'b0;
    drops_m = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int partial;
    apply_reset();

    // Full packet of counting words: tlast only on the fourth.
    fill_words(4, 1'b0, '0);
    send_frame(0);
    wait_drain();
    check_status("packet");

    // One-word frame: delivered, and the short packet is flagged.
    frame_words.delete();
    frame_words.push_back(32'hA5A5_0F0F);
    send_frame(0);
    wait_drain();
    check_status("single");
    do_clr();
    check_status("clear1");

    // Partial word of 12 bits: no beat, frame error; next packet intact.
    frame_words.delete();
    send_frame(3);
    check_status("partial");
    fill_words(4, 1'b1, '0);
    send_frame(0);
    wait_drain();
    check_status("after_partial");
    do_clr();

    // Overflow: six words into a four-deep FIFO with tready held low.
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    fill_words(6, 1'b0, 32'h0000_0100);
    send_frame(0);
    check_status("overflow");
    rdy_mode = 0;
    wait_drain();
    do_clr();
    check_status("overflow_clr");

    // Reset in the middle of a word, then a fresh packet.
    send_group(4'h9, 1'b1);
    send_group(4'h6, 1'b1);
    apply_reset();
    fill_words(4, 1'b1, '0);
    send_frame(0);
    wait_drain();
    check_status("post_reset");

    // Random frames with a randomly toggling tready.
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 6);
      partial = ($urandom_range(0, 2) == 0) ? $urandom_range(1, GROUPS - 1) : 0;
      fill_words(n, 1'b1, '0);
      send_frame(partial);
    end
    wait_drain();
    check_status("random");
    rdy_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
